// File: rtl/piso_stream_ctrl_pkg.sv
// Shared definitions for the PISO stream controller: FSM state encoding and
// a width helper used to size the bit and gap counters.
package piso_stream_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Bits needed to count 0..value-1, never less than one.
   function automatic int clog2_min1(input int value);
      int width;
      width = 0;
      while ((1 << width) < value) width = width + 1;
      return (width < 1) ? 1 : width;
   endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in/serial-out shift register datapath. Load wins over shift; the
// register zero-fills as bits leave through the output end.
module piso_shreg #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             q
);

   logic [WIDTH-1:0] data;

   // NOTE: sequential state is written with <= so every flop samples the
   // pre-edge values, independent of statement order across processes.
   always_ff @(posedge clk) begin
      if (reset) begin
         data <= '0;
      end else if (load) begin
         data <= d;
      end else if (shift) begin
         data <= MSB_FIRST ? (data << 1) : (data >> 1);
      end
   end

   assign q = MSB_FIRST ? data[WIDTH-1] : data[0];

endmodule

// File: rtl/piso_stream_ctrl.sv
// Serializer controller: accepts words over valid/ready, drives the PISO
// datapath and frames the serial stream with an optional idle gap per word.
module piso_stream_ctrl
   import piso_stream_ctrl_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter int GAP       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pi,
   input  logic             pi_valid,
   output logic             pi_ready,
   output logic             so,
   output logic             so_valid,
   output logic             so_first,
   output logic             so_last,
   output logic             busy
);

   localparam int CW = clog2_min1(WIDTH);
   localparam int GW = clog2_min1(GAP);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? GAP - 1 : 0);

   state_t          state, state_next;
   logic [CW-1:0]   bit_cnt, bit_cnt_next;
   logic [GW-1:0]   gap_cnt, gap_cnt_next;
   logic            load, shift, shreg_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         state   <= state_next;
         bit_cnt <= bit_cnt_next;
         gap_cnt <= gap_cnt_next;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      gap_cnt_next = gap_cnt;
      load         = 1'b0;
      shift        = 1'b0;
      pi_ready     = 1'b0;
      so_valid     = 1'b0;
      so_first     = 1'b0;
      so_last      = 1'b0;

      unique case (state)
         ST_IDLE: begin
            pi_ready = !reset;
            if (pi_valid && pi_ready) begin
               load         = 1'b1;
               bit_cnt_next = '0;
               state_next   = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            so_valid     = 1'b1;
            so_first     = (bit_cnt == '0);
            so_last      = (bit_cnt == LAST_BIT);
            shift        = 1'b1;
            bit_cnt_next = bit_cnt + 1'b1;
            if (so_last) begin
               bit_cnt_next = '0;
               if (GAP > 0) begin
                  gap_cnt_next = '0;
                  state_next   = ST_GAP;
               end else begin
                  // Back-to-back handoff: a reload here keeps so_valid high.
                  pi_ready = !reset;
                  if (pi_valid && pi_ready) load = 1'b1;
                  else                      state_next = ST_IDLE;
               end
            end
         end

         ST_GAP: begin
            if (gap_cnt == LAST_GAP) state_next = ST_IDLE;
            else                     gap_cnt_next = gap_cnt + 1'b1;
         end

         default: state_next = ST_IDLE;
      endcase
   end

   piso_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .shift (shift),
      .d     (pi),
      .q     (shreg_q)
   );

   assign so   = so_valid & shreg_q;
   assign busy = (state != ST_IDLE);

endmodule
